// File: rtl/tmds_pkg.sv
// TMDS control tokens and alignment-FSM states shared by the receive path.
// Constants only: no latency, no flow control.
package tmds_pkg;

   localparam logic [9:0] CTRL_00 = 10'b1101010100;
   localparam logic [9:0] CTRL_01 = 10'b0010101011;
   localparam logic [9:0] CTRL_10 = 10'b0101010100;
   localparam logic [9:0] CTRL_11 = 10'b1010101011;

   localparam logic [3:0] SLIP_MAX = 4'd9;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SLIP   = 2'd1,
      LOCKED = 2'd2
   } align_state_t;

   function automatic logic is_ctrl_token(input logic [9:0] word);
      return (word == CTRL_00) || (word == CTRL_01) ||
             (word == CTRL_10) || (word == CTRL_11);
   endfunction

endpackage

// File: rtl/word_align_fsm.sv
// Word-alignment FSM: hunts for control tokens, slips one bit per search window; updates on word_stb.
// No backpressure: one decision per strobe, slip/locked registered and valid from the following cycle.
module word_align_fsm
   import tmds_pkg::*;
#(
   parameter int LOCK_TOKENS  = 8,
   parameter int SEARCH_WORDS = 2048,
   parameter int LOSS_WORDS   = 4096
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       word_stb,
   input  logic       is_token,
   output logic [3:0] slip,
   output logic       locked
);

   localparam int TW = (LOCK_TOKENS  > 1) ? $clog2(LOCK_TOKENS)  : 1;
   localparam int WW = (SEARCH_WORDS > 1) ? $clog2(SEARCH_WORDS) : 1;
   localparam int GW = (LOSS_WORDS   > 1) ? $clog2(LOSS_WORDS)   : 1;

   // Counters stop one short of their threshold; the threshold is detected on the increment.
   localparam logic [TW-1:0] TOK_LAST  = TW'(LOCK_TOKENS - 1);
   localparam logic [WW-1:0] WORD_LAST = WW'(SEARCH_WORDS - 1);
   localparam logic [WW-1:0] WORD_TRIG = WW'(SEARCH_WORDS - 2);
   localparam logic [GW-1:0] GAP_LAST  = GW'(LOSS_WORDS - 1);

   align_state_t  state, state_nxt;
   logic [TW-1:0] tok_cnt, tok_nxt;
   logic [WW-1:0] word_cnt, word_nxt;
   logic [GW-1:0] gap_cnt, gap_nxt;
   logic [3:0]    slip_nxt;
   logic          locked_nxt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= HUNT;
         tok_cnt  <= '0;
         word_cnt <= '0;
         gap_cnt  <= '0;
         slip     <= '0;
         locked   <= 1'b0;
      end else begin
         state    <= state_nxt;
         tok_cnt  <= tok_nxt;
         word_cnt <= word_nxt;
         gap_cnt  <= gap_nxt;
         slip     <= slip_nxt;
         locked   <= locked_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      tok_nxt    = tok_cnt;
      word_nxt   = word_cnt;
      gap_nxt    = gap_cnt;
      slip_nxt   = slip;
      locked_nxt = locked;
      if (word_stb) begin
         case (state)
            HUNT: begin
               if (!is_token)
                  tok_nxt = '0;
               else if (tok_cnt < TOK_LAST)
                  tok_nxt = tok_cnt + 1'b1;
               if (word_cnt < WORD_LAST)
                  word_nxt = word_cnt + 1'b1;
               // Lock wins over slip when both trigger on the same word.
               if (is_token && (tok_cnt >= TOK_LAST)) begin
                  state_nxt  = LOCKED;
                  locked_nxt = 1'b1;
                  gap_nxt    = '0;
                  tok_nxt    = '0;
                  word_nxt   = '0;
               end else if (word_cnt >= WORD_TRIG) begin
                  state_nxt = SLIP;
               end
            end
            SLIP: begin
               slip_nxt  = (slip >= SLIP_MAX) ? 4'd0 : slip + 4'd1;
               tok_nxt   = '0;
               word_nxt  = '0;
               state_nxt = HUNT;
            end
            LOCKED: begin
               if (is_token) begin
                  gap_nxt = '0;
               end else if (gap_cnt >= GAP_LAST) begin
                  // Keep slip so the same offset is retried first.
                  state_nxt  = HUNT;
                  locked_nxt = 1'b0;
                  gap_nxt    = '0;
                  tok_nxt    = '0;
                  word_nxt   = '0;
               end else begin
                  gap_nxt = gap_cnt + 1'b1;
               end
            end
            default: begin
               state_nxt  = HUNT;
               locked_nxt = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/ser_to_par.sv
// 10:1 TMDS deserializer: bit pairs in, 10-bit word every 5 clk_5x, bit-slip alignment; 6-10 cycle latency.
// No backpressure: input must be a continuous stream, data_valid is a free-running one-in-five strobe.
module ser_to_par
   import tmds_pkg::*;
#(
   parameter int LOCK_TOKENS  = 8,
   parameter int SEARCH_WORDS = 2048,
   parameter int LOSS_WORDS   = 4096
) (
   input  logic       clk_5x,
   input  logic       sys_rst_n,
   input  logic       ser_rise,
   input  logic       ser_fall,
   output logic [9:0] data_out,
   output logic       data_valid,
   output logic       locked,
   output logic [3:0] slip_pos
);

   logic [19:0] hist;
   logic [2:0]  phase;
   logic [9:0]  word;
   logic        word_stb;
   logic        is_token;

   assign word_stb = (phase == 3'd4);
   assign is_token = is_ctrl_token(word);

   // Oldest bit sits at hist[0]; the slip offset picks a 10-bit window upward from there.
   always_comb begin
      word = '0;
      for (int i = 0; i < 10; i++)
         word[i] = hist[5'(i) + {1'b0, slip_pos}];
   end

   always_ff @(posedge clk_5x) begin
      if (!sys_rst_n) begin
         hist       <= '0;
         phase      <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
      end else begin
         hist       <= {ser_fall, ser_rise, hist[19:2]};
         phase      <= word_stb ? 3'd0 : phase + 3'd1;
         data_valid <= word_stb;
         if (word_stb)
            data_out <= word;
      end
   end

   word_align_fsm #(
      .LOCK_TOKENS  (LOCK_TOKENS),
      .SEARCH_WORDS (SEARCH_WORDS),
      .LOSS_WORDS   (LOSS_WORDS)
   ) u_align (
      .clk      (clk_5x),
      .rst_n    (sys_rst_n),
      .word_stb (word_stb),
      .is_token (is_token),
      .slip     (slip_pos),
      .locked   (locked)
   );

endmodule

// File: tb/tb_ser_to_par.sv
// Directed bench for ser_to_par with shortened search/loss windows; words are numbered 1.. from reset release.
// Character j of a stream starts at bit 8+off+10j, so at slip==off word k carries character k-3.
module tb_ser_to_par;
   import tmds_pkg::*;

   localparam int LT = 8;
   localparam int SW = 16;
   localparam int LW = 32;

   logic       clk_5x = 1'b0;
   logic       sys_rst_n;
   logic       ser_rise;
   logic       ser_fall;
   logic [9:0] data_out;
   logic       data_valid;
   logic       locked;
   logic [3:0] slip_pos;

   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   int   wcnt   = 0;
   int   mode   = 0;
   int   off    = 0;
   logic ever_locked;

   always #5 clk_5x = ~clk_5x;

   ser_to_par #(
      .LOCK_TOKENS  (LT),
      .SEARCH_WORDS (SW),
      .LOSS_WORDS   (LW)
   ) dut (
      .clk_5x     (clk_5x),
      .sys_rst_n  (sys_rst_n),
      .ser_rise   (ser_rise),
      .ser_fall   (ser_fall),
      .data_out   (data_out),
      .data_valid (data_valid),
      .locked     (locked),
      .slip_pos   (slip_pos)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // mode 0: tokens with a 32-word non-token gap; mode 1: tokens; mode 2: 7 tokens then one 0x1F0.
   function automatic logic [9:0] char_of(input int j);
      case (mode)
         0:       return (j < 2 || (j >= 20 && j < 52)) ? 10'h1F0 : CTRL_00;
         1:       return (j < 2) ? 10'h1F0 : CTRL_00;
         default: return ((j % 8) == 7) ? 10'h1F0 : CTRL_00;
      endcase
   endfunction

   function automatic logic bit_at(input int n);
      int         p;
      logic [9:0] c;
      p = n - (8 + off);
      if (p < 0)
         return 1'b0;
      c = char_of(p / 10);
      return c[p % 10];
   endfunction

   task automatic tick();
      @(negedge clk_5x);
      ser_rise = bit_at(2 * cyc);
      ser_fall = bit_at(2 * cyc + 1);
      cyc++;
      @(posedge clk_5x);
      #1;
      if (data_valid) wcnt++;
      if (locked) ever_locked = 1'b1;
   endtask

   task automatic reset_hold(input int n);
      sys_rst_n = 1'b0;
      repeat (n) tick();
      sys_rst_n   = 1'b1;
      cyc         = 0;
      wcnt        = 0;
      ever_locked = 1'b0;
   endtask

   task automatic run_to(input int n);
      int guard;
      guard = 0;
      while (wcnt < n && guard < 5 * n + 50) begin
         tick();
         guard++;
      end
      check($sformatf("word_count_%0d", n), wcnt, n);
   endtask

   initial begin
      sys_rst_n   = 1'b0;
      ser_rise    = 1'b0;
      ser_fall    = 1'b0;
      ever_locked = 1'b0;

      // Reset and strobe cadence
      mode = 0; off = 0;
      reset_hold(10);
      check("rst_data_out", data_out, 0);
      check("rst_data_valid", data_valid, 0);
      check("rst_locked", locked, 0);
      check("rst_slip_pos", slip_pos, 0);
      repeat (4) tick();
      check("dv_cycle4", data_valid, 0);
      tick();
      check("dv_cycle5", data_valid, 1);
      check("first_word_zero", data_out, 0);
      repeat (4) tick();
      check("dv_cycle9", data_valid, 0);
      tick();
      check("dv_cycle10", data_valid, 1);

      // Aligned stream: tokens from word 5, lock on the 8th
      run_to(11);
      check("aligned_not_yet", locked, 0);
      run_to(12);
      check("aligned_lock", locked, 1);
      check("aligned_word", data_out, 10'h354);
      check("aligned_slip", slip_pos, 0);

      // Lock loss: non-tokens on words 23..54, recovery on 55..62
      run_to(53);
      check("loss_still_locked", locked, 1);
      run_to(54);
      check("loss_dropped", locked, 0);
      check("loss_word", data_out, 10'h1F0);
      check("loss_slip_kept", slip_pos, 0);
      run_to(61);
      check("relock_not_yet", locked, 0);
      run_to(62);
      check("relock", locked, 1);
      check("relock_word", data_out, 10'h354);

      // Offset 3: slip steps at words 16, 32, 48, lock on word 56
      mode = 1; off = 3;
      reset_hold(3);
      run_to(15);
      check("off_slip_w15", slip_pos, 0);
      run_to(16);
      check("off_slip_w16", slip_pos, 1);
      run_to(32);
      check("off_slip_w32", slip_pos, 2);
      run_to(47);
      check("off_slip_w47", slip_pos, 2);
      run_to(48);
      check("off_slip_w48", slip_pos, 3);
      run_to(55);
      check("off_not_yet", locked, 0);
      run_to(56);
      check("off_lock", locked, 1);
      check("off_word", data_out, 10'h354);
      check("off_slip_locked", slip_pos, 3);

      // Reset on the cycle that would otherwise strobe a word
      run_to(60);
      repeat (4) tick();
      check("pre_reset_dv", data_valid, 0);
      sys_rst_n = 1'b0;
      tick();
      check("midrst_dv", data_valid, 0);
      check("midrst_locked", locked, 0);
      check("midrst_slip", slip_pos, 0);
      check("midrst_data", data_out, 0);
      reset_hold(2);
      run_to(56);
      check("rehunt_lock", locked, 1);
      check("rehunt_slip", slip_pos, 3);

      // Offset 9 with 7-token runs: never locks, slip wraps 9 -> 0 at word 160
      mode = 2; off = 9;
      reset_hold(3);
      run_to(144);
      check("wrap_slip_w144", slip_pos, 9);
      run_to(159);
      check("wrap_slip_w159", slip_pos, 9);
      run_to(160);
      check("wrap_slip_w160", slip_pos, 0);
      run_to(176);
      check("wrap_slip_w176", slip_pos, 1);
      check("wrap_never_locked", ever_locked, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
